sram_bytelane: RTL and testbench
================================

# sram_bytelane

Parametrised single-port synchronous SRAM with generic byte-lane write enables, a registered one-cycle read path with a valid strobe, and a sequential post-reset clear engine. It replaces the combinational-read, reset-cleared SRAM model for any data width that is a multiple of 8 and any depth, and maps onto vendor RAM macros because the array itself is never reset. It sits behind the bus-to-memory interface and serves as instruction or data memory.

## Interface
- DATAWIDTH, 32, word width in bits; must be a multiple of 8
- ADDRWIDTH, 16, address width in bits
- MEMDEPTH, 1 << ADDRWIDTH, number of implemented words; 1 ≤ MEMDEPTH ≤ 2^ADDRWIDTH
- NBYTES (localparam), DATAWIDTH/8, number of byte lanes

- CLK  input  1  single clock; all logic on the rising edge
- RSTn  input  1  asynchronous active-low reset
- ADDRESS  input  ADDRWIDTH  word address
- CS  input  1  access request; sampled only while READY=1
- WE  input  NBYTES  per-byte write enable; all zero means read
- WDATA  input  DATAWIDTH  write data; lane i is bits [8i+7:8i]
- PINJ  input  1  parity error injection; ignored without SRAM_PARITY_EN
- RDATA  output  DATAWIDTH  registered read data
- RVALID  output  1  one-cycle strobe: RDATA updated by a read
- READY  output  1  clear engine finished; accesses accepted
- PERR  output  1  parity error on the current RVALID beat

## Operation
- States: INIT, RUN. Reset forces INIT with clear counter = 0.
- INIT: each rising edge writes all-zero data (and zero parity) to word[counter] and increments the counter. The edge that clears word MEMDEPTH-1 moves the block to RUN and sets READY=1. CS, WE, ADDRESS and WDATA are ignored in INIT.
- RUN: an access is accepted on every edge with CS=1.
  - WE≠0: lane i is replaced by WDATA lane i when WE[i]=1; other lanes keep their stored value. RVALID is not asserted.
  - WE=0: RDATA takes word[ADDRESS] and RVALID=1 for exactly one cycle.
- RDATA holds its last read value until the next read. It is not zeroed when idle or on writes.
- ADDRESS ≥ MEMDEPTH: writes are dropped and leave the array unchanged. Reads return 0 with RVALID=1 and PERR=0.
- Reset in either state: outputs go to reset values immediately and INIT restarts from word 0. Array contents are undefined until the clear completes.

## Timing
- Reset values: RDATA=0, RVALID=0, READY=0, PERR=0.
- Clear latency: READY rises on the MEMDEPTH-th rising edge after RSTn deasserts.
- Read latency: one cycle. For a read sampled at edge N, RDATA, RVALID and PERR are valid after edge N and RVALID drops after edge N+1 unless a new read is sampled there. Back-to-back reads give one beat per cycle.
- Write at edge N followed by a read of the same address at edge N+1 returns the new data. There is no bypass hazard.
- There is no backpressure. Every accepted read produces exactly one RVALID beat.

## Configuration
- SRAM_PARITY_EN defined:
  - The array stores NBYTES extra bits, one even-parity bit per byte.
  - A write computes parity for each enabled lane. If PINJ=1 during the write, the parity of every enabled lane is stored inverted.
  - A read recomputes parity over all lanes. PERR=1 alongside RVALID if any lane mismatches. RDATA is returned unmodified.
- SRAM_PARITY_EN undefined:
  - No parity storage.
  - PINJ is ignored and PERR is constant 0.

## Test plan
- Clear sequence, MEMDEPTH=16, ADDRWIDTH=4. Release reset → READY=0 for 15 edges and 1 after the 16th edge. Reads of addresses 0..15 return 0, with RVALID one cycle after each request.
- Byte-lane write, DATAWIDTH=32. Write 0x11223344 with WE=4'hF, then 0xAABBCCDD with WE=4'b0101, then read → RDATA=0x11BB33DD with a single RVALID pulse.
- Access during INIT and pipelined reads. CS=1 with WE=4'hF, WDATA=0xFFFFFFFF during INIT has no effect: a read after READY returns 0. Then read 3 consecutive addresses on 3 consecutive edges → 3 RVALID beats carrying the correct data in order.
- Out of range, MEMDEPTH=12, ADDRWIDTH=4. Write 0xDEADBEEF to address 13 and read address 13 → RDATA=0, RVALID=1. Addresses 0..11 are unchanged.
- Reset mid-operation. Write 0x12345678 to address 3 and assert RSTn=0 during a pending read → RVALID, READY and RDATA go to 0 asynchronously. After the clear completes, a read of address 3 returns 0.
- Parity, with SRAM_PARITY_EN. Write 0xA5A5A5A5 with WE=4'b0010 and PINJ=1, then read → RVALID=1, PERR=1. Rewrite with PINJ=0, then read → PERR=0. Without the macro, the same sequence keeps PERR=0.

Source files
------------

// File: rtl/sram_bytelane.sv
// ---------------------------------------------------------------------------
// sram_bytelane
//
// Single-port synchronous SRAM with per-byte write enables, a registered
// one-cycle read path with a valid strobe, and a sequential clear engine that
// zeroes every word after reset. The storage array itself has no reset so it
// can map onto vendor RAM macros; only the control path is reset.
//
// Optional feature: define SRAM_PARITY_EN to store one even-parity bit per
// byte lane and flag mismatches on PERR. Without it PINJ is ignored and PERR
// is tied low.
//
// Parameters
//   DATAWIDTH  word width in bits (multiple of 8)
//   ADDRWIDTH  address width in bits
//   MEMDEPTH   implemented words, 1 .. 2**ADDRWIDTH
//
// Ports
//   CLK      rising-edge clock
//   RSTn     asynchronous active-low reset
//   ADDRESS  word address
//   CS       access request, sampled only while READY=1
//   WE       per-byte write enable, all zero selects a read
//   WDATA    write data, lane i is bits [8i+7:8i]
//   PINJ     invert stored parity of enabled lanes (parity build only)
//   RDATA    registered read data, held until the next read
//   RVALID   one-cycle strobe marking a read beat
//   READY    clear engine finished, accesses accepted
//   PERR     parity mismatch on the current RVALID beat
// ---------------------------------------------------------------------------
module sram_bytelane #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 16,
   parameter int MEMDEPTH  = 1 << ADDRWIDTH
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic [ADDRWIDTH-1:0]     ADDRESS,
   input  logic                     CS,
   input  logic [DATAWIDTH/8-1:0]   WE,
   input  logic [DATAWIDTH-1:0]     WDATA,
   input  logic                     PINJ,
   output logic [DATAWIDTH-1:0]     RDATA,
   output logic                     RVALID,
   output logic                     READY,
   output logic                     PERR
);

   localparam int NBYTES = DATAWIDTH / 8;
   localparam int IDXW   = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
   localparam logic [ADDRWIDTH-1:0] CNT_LAST = ADDRWIDTH'(MEMDEPTH - 1);
   // One extra bit so a full-depth array (MEMDEPTH = 2**ADDRWIDTH) compares correctly.
   localparam logic [ADDRWIDTH:0]   DEPTH_X  = (ADDRWIDTH + 1)'(MEMDEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADDRWIDTH-1:0]   clr_cnt_q, clr_cnt_d;

   logic                   in_range_p0;
   logic                   rd_en_p0;
   logic [NBYTES-1:0]      wr_be_p0;
   logic [IDXW-1:0]        wr_idx_p0;
   logic [IDXW-1:0]        rd_idx_p0;
   logic [DATAWIDTH-1:0]   wr_data_p0;

   logic [DATAWIDTH-1:0]   mem [MEMDEPTH];
   logic [DATAWIDTH-1:0]   mem_rd_p1;
   logic                   vld_p1;
   logic                   keep_p1;

   assign in_range_p0 = ({1'b0, ADDRESS} < DEPTH_X);
   assign rd_idx_p0   = ADDRESS[IDXW-1:0];

   // ---- stage p0: access decode / clear engine ----
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      rd_en_p0   = 1'b0;
      wr_be_p0   = '0;
      wr_idx_p0  = ADDRESS[IDXW-1:0];
      wr_data_p0 = WDATA;
      case (state_q)
         INIT: begin
            // Bus inputs are ignored; the engine owns the write port.
            wr_be_p0   = '1;
            wr_idx_p0  = clr_cnt_q[IDXW-1:0];
            wr_data_p0 = '0;
            clr_cnt_d  = clr_cnt_q + ADDRWIDTH'(1);
            if (clr_cnt_q == CNT_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (CS) begin
               if (WE == '0) begin
                  rd_en_p0 = 1'b1;
               end else if (in_range_p0) begin
                  wr_be_p0 = WE;
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= INIT;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // ---- stage p1: array access and read register ----
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NBYTES; i++) begin
         if (wr_be_p0[i]) begin
            mem[wr_idx_p0][8*i +: 8] <= wr_data_p0[8*i +: 8];
         end
      end
      if (rd_en_p0 && in_range_p0) begin
         mem_rd_p1 <= mem[rd_idx_p0];
      end
   end

   // keep_p1 zeroes RDATA after reset and for out-of-range reads without
   // putting a reset on the RAM output register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         vld_p1  <= 1'b0;
         keep_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_en_p0;
         if (rd_en_p0) begin
            keep_p1 <= in_range_p0;
         end
      end
   end

   assign RDATA  = mem_rd_p1 & {DATAWIDTH{keep_p1}};
   assign RVALID = vld_p1;
   assign READY  = (state_q == RUN);

`ifdef SRAM_PARITY_EN
   function automatic logic [NBYTES-1:0] lane_parity(input logic [DATAWIDTH-1:0] d);
      logic [NBYTES-1:0] p;
      for (int i = 0; i < NBYTES; i++) begin
         p[i] = ^d[8*i +: 8];
      end
      return p;
   endfunction

   logic [NBYTES-1:0] par_mem [MEMDEPTH];
   logic [NBYTES-1:0] wr_par_p0;
   logic [NBYTES-1:0] par_rd_p1;

   // Clear writes zero data with zero parity, which is consistent even parity.
   assign wr_par_p0 = (state_q == INIT) ? '0 : (lane_parity(WDATA) ^ {NBYTES{PINJ}});

   always_ff @(posedge CLK) begin
      for (int i = 0; i < NBYTES; i++) begin
         if (wr_be_p0[i]) begin
            par_mem[wr_idx_p0][i] <= wr_par_p0[i];
         end
      end
      if (rd_en_p0 && in_range_p0) begin
         par_rd_p1 <= par_mem[rd_idx_p0];
      end
   end

   assign PERR = vld_p1 & keep_p1 & (|(lane_parity(mem_rd_p1) ^ par_rd_p1));
`else
   logic unused_pinj;
   assign unused_pinj = PINJ;
   assign PERR        = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bytelane.sv
// ---------------------------------------------------------------------------
// tb_sram_bytelane
//
// Directed bench for sram_bytelane. Two instances share all inputs: u_a has
// MEMDEPTH=12 (partial depth, addresses 12..15 out of range) and u_b has
// MEMDEPTH=16 (full 4-bit address space). Outputs are sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_sram_bytelane;

`ifdef SRAM_PARITY_EN
   localparam logic PAR = 1'b1;
`else
   localparam logic PAR = 1'b0;
`endif

   logic        CLK;
   logic        RSTn;
   logic [3:0]  ADDRESS;
   logic        CS;
   logic [3:0]  WE;
   logic [31:0] WDATA;
   logic        PINJ;

   logic [31:0] rdata_a, rdata_b;
   logic        rvalid_a, rvalid_b, ready_a, ready_b, perr_a, perr_b;

   int vectors  = 0;
   int failures = 0;

   logic [31:0] mdl_a [16];
   logic [31:0] mdl_b [16];
   logic [31:0] last_a, last_b;

   sram_bytelane #(.DATAWIDTH(32), .ADDRWIDTH(4), .MEMDEPTH(12)) u_a (
      .CLK(CLK), .RSTn(RSTn), .ADDRESS(ADDRESS), .CS(CS), .WE(WE),
      .WDATA(WDATA), .PINJ(PINJ), .RDATA(rdata_a), .RVALID(rvalid_a),
      .READY(ready_a), .PERR(perr_a)
   );

   sram_bytelane #(.DATAWIDTH(32), .ADDRWIDTH(4), .MEMDEPTH(16)) u_b (
      .CLK(CLK), .RSTn(RSTn), .ADDRESS(ADDRESS), .CS(CS), .WE(WE),
      .WDATA(WDATA), .PINJ(PINJ), .RDATA(rdata_b), .RVALID(rvalid_b),
      .READY(ready_b), .PERR(perr_b)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_models();
      for (int i = 0; i < 16; i++) begin
         mdl_a[i] = '0;
         mdl_b[i] = '0;
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [3:0] we,
                           input logic [31:0] d, input logic pinj);
      CS = 1'b1; WE = we; ADDRESS = a; WDATA = d; PINJ = pinj;
      @(posedge CLK); #1;
      CS = 1'b0; WE = '0; PINJ = 1'b0;
      for (int l = 0; l < 4; l++) begin
         if (we[l]) begin
            if (a < 12) mdl_a[a][8*l +: 8] = d[8*l +: 8];
            mdl_b[a][8*l +: 8] = d[8*l +: 8];
         end
      end
      chk("wr_rvalid_a", {31'b0, rvalid_a}, 32'd0);
      chk("wr_rvalid_b", {31'b0, rvalid_b}, 32'd0);
   endtask

   task automatic do_read(input logic [3:0] a, input logic pexp);
      logic [31:0] ea, eb;
      CS = 1'b1; WE = '0; ADDRESS = a;
      @(posedge CLK); #1;
      CS = 1'b0;
      ea = (a < 12) ? mdl_a[a] : 32'd0;
      eb = mdl_b[a];
      chk("rd_rvalid_a", {31'b0, rvalid_a}, 32'd1);
      chk("rd_rvalid_b", {31'b0, rvalid_b}, 32'd1);
      chk("rd_data_a", rdata_a, ea);
      chk("rd_data_b", rdata_b, eb);
      chk("rd_perr_a", {31'b0, perr_a}, {31'b0, (a < 12) ? pexp : 1'b0});
      chk("rd_perr_b", {31'b0, perr_b}, {31'b0, pexp});
      last_a = ea;
      last_b = eb;
   endtask

   task automatic idle_check();
      CS = 1'b0;
      @(posedge CLK); #1;
      chk("idle_rvalid_a", {31'b0, rvalid_a}, 32'd0);
      chk("idle_rvalid_b", {31'b0, rvalid_b}, 32'd0);
      chk("idle_hold_a", rdata_a, last_a);
      chk("idle_hold_b", rdata_b, last_b);
   endtask

   initial begin
      int n;
      RSTn = 1'b1; CS = 1'b0; WE = '0; ADDRESS = '0; WDATA = '0; PINJ = 1'b0;
      last_a = '0; last_b = '0;
      clear_models();

      // Reset values
      #1 RSTn = 1'b0;
      #1;
      chk("rst_rdata_a", rdata_a, 32'd0);
      chk("rst_rdata_b", rdata_b, 32'd0);
      chk("rst_rvalid_a", {31'b0, rvalid_a}, 32'd0);
      chk("rst_rvalid_b", {31'b0, rvalid_b}, 32'd0);
      chk("rst_ready_a", {31'b0, ready_a}, 32'd0);
      chk("rst_ready_b", {31'b0, ready_b}, 32'd0);
      chk("rst_perr_a", {31'b0, perr_a}, 32'd0);
      chk("rst_perr_b", {31'b0, perr_b}, 32'd0);
      repeat (2) @(posedge CLK);

      // Clear sequence with write attempts during INIT
      CS = 1'b1; WE = 4'hF; WDATA = 32'hFFFF_FFFF; ADDRESS = 4'd0;
      @(negedge CLK) RSTn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(posedge CLK); #1;
         chk($sformatf("clr_ready_a_%0d", i), {31'b0, ready_a}, {31'b0, (i >= 12)});
         chk($sformatf("clr_ready_b_%0d", i), {31'b0, ready_b}, {31'b0, (i >= 16)});
         chk("clr_rvalid_a", {31'b0, rvalid_a}, 32'd0);
         if (i >= 12) begin
            CS = 1'b0; WE = '0;
         end else begin
            ADDRESS = 4'(i);
         end
      end

      // Cleared contents, including the INIT write attempts
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), 1'b0);
      end
      idle_check();

      // Byte-lane merge
      do_write(4'd2, 4'hF, 32'h1122_3344, 1'b0);
      do_write(4'd2, 4'b0101, 32'hAABB_CCDD, 1'b0);
      do_read(4'd2, 1'b0);
      chk("lane_merge_a", rdata_a, 32'h11BB_33DD);
      chk("lane_merge_b", rdata_b, 32'h11BB_33DD);
      idle_check();

      // Back-to-back reads and write followed by immediate read
      do_write(4'd4, 4'hF, 32'h0404_0404, 1'b0);
      do_write(4'd5, 4'hF, 32'h0505_0505, 1'b0);
      do_write(4'd6, 4'hF, 32'h0606_0606, 1'b0);
      do_read(4'd4, 1'b0);
      do_read(4'd5, 1'b0);
      do_read(4'd6, 1'b0);
      chk("pipe_last_b", rdata_b, 32'h0606_0606);
      idle_check();
      do_write(4'd7, 4'hF, 32'h7777_7777, 1'b0);
      do_read(4'd7, 1'b0);
      chk("wr_then_rd_a", rdata_a, 32'h7777_7777);

      // Out of range on u_a, in range on u_b
      do_write(4'd13, 4'hF, 32'hDEAD_BEEF, 1'b0);
      do_read(4'd13, 1'b0);
      chk("oor_rdata_a", rdata_a, 32'd0);
      chk("oor_rdata_b", rdata_b, 32'hDEAD_BEEF);
      for (int a = 0; a < 12; a++) begin
         do_read(4'(a), 1'b0);
      end
      do_write(4'd15, 4'hF, 32'hCAFE_F00D, 1'b0);
      do_read(4'd15, 1'b0);
      chk("top_word_b", rdata_b, 32'hCAFE_F00D);
      idle_check();

      // Parity injection on lane 1
      do_write(4'd8, 4'b0010, 32'hA5A5_A5A5, 1'b1);
      do_read(4'd8, PAR);
      chk("par_data_a", rdata_a, 32'h0000_A500);
      do_write(4'd8, 4'b0010, 32'hA5A5_A5A5, 1'b0);
      do_read(4'd8, 1'b0);
      idle_check();

      // Reset during a pending read beat
      do_write(4'd3, 4'hF, 32'h1234_5678, 1'b0);
      CS = 1'b1; WE = '0; ADDRESS = 4'd3;
      @(posedge CLK); #1;
      chk("mid_rvalid_b", {31'b0, rvalid_b}, 32'd1);
      chk("mid_rdata_b", rdata_b, 32'h1234_5678);
      #2 RSTn = 1'b0;
      #1;
      CS = 1'b0;
      chk("arst_rvalid_a", {31'b0, rvalid_a}, 32'd0);
      chk("arst_rvalid_b", {31'b0, rvalid_b}, 32'd0);
      chk("arst_ready_a", {31'b0, ready_a}, 32'd0);
      chk("arst_ready_b", {31'b0, ready_b}, 32'd0);
      chk("arst_rdata_a", rdata_a, 32'd0);
      chk("arst_rdata_b", rdata_b, 32'd0);
      @(negedge CLK) RSTn = 1'b1;
      n = 0;
      while (!ready_b && n < 40) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("reclear_done_b", {31'b0, ready_b}, 32'd1);
      chk("reclear_latency_b", 32'(n), 32'd16);
      chk("reclear_done_a", {31'b0, ready_a}, 32'd1);
      clear_models();
      do_read(4'd3, 1'b0);
      chk("post_rst_rd3_b", rdata_b, 32'd0);
      idle_check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
      $finish;
   end

endmodule
